// File: rtl/clock_display_driver_if.sv
// -----------------------------------------------------------------------------
// clock_display_driver_if
//
// Purpose:
//   Bundles the time-of-day inputs and the 7-segment pin outputs of
//   clock_display_driver into one interface so the upstream counter (or a
//   bench) and the display driver connect through a single port.
//
// Signals:
//   seconds_i  [5:0]  binary seconds, valid 0-59
//   minutes_i  [5:0]  binary minutes, valid 0-59
//   hours_i    [4:0]  binary hours, valid 0-23
//   an_o       [7:0]  digit anodes, active-low, bit 7 = leftmost digit
//   dec_cat_o  [7:0]  cathodes, active-low, [7]=dp, [6:0]=g,f,e,d,c,b,a
//
// Modports:
//   master : time source side, drives the time fields and observes the pins
//   slave  : display driver side, reads the time fields and drives the pins
// -----------------------------------------------------------------------------
interface clock_display_driver_if;

  logic [5:0] seconds_i;
  logic [5:0] minutes_i;
  logic [4:0] hours_i;
  logic [7:0] an_o;
  logic [7:0] dec_cat_o;

  modport master (
    output seconds_i,
    output minutes_i,
    output hours_i,
    input  an_o,
    input  dec_cat_o
  );

  modport slave (
    input  seconds_i,
    input  minutes_i,
    input  hours_i,
    output an_o,
    output dec_cat_o
  );

endinterface

// File: rtl/clock_display_driver.sv
// -----------------------------------------------------------------------------
// clock_display_driver
//
// Purpose:
//   Downstream stage of the time-of-day counter. Takes binary hours, minutes
//   and seconds and time-multiplexes them onto an 8-digit common-anode
//   7-segment display as HH-MM-SS. The time is snapshotted once per scan
//   frame so a field never tears while the digits are being scanned.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_DIV
//
// Ports:
//   clk_100MHz_i  system clock
//   reset_i       asynchronous reset, active-high, display dark while high
//   disp          clock_display_driver_if.slave
//                   seconds_i/minutes_i/hours_i  time fields in
//                   an_o                         anodes, active-low
//                   dec_cat_o                    cathodes, active-low
//
// Configuration macro:
//   SEPARATOR_BLINK_EN  when defined, the two dash digits blink with the
//                       snapshot seconds LSB (lit on even, blank on odd).
//                       When undefined, the dashes are always lit.
// -----------------------------------------------------------------------------
module clock_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                   clk_100MHz_i,
  input  logic                   reset_i,
  clock_display_driver_if.slave  disp
);

  // Active-low cathode codes, bit 7 (dp) always high.
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] refreshCnt_q, refreshCnt_d;
  logic [2:0]       index_q, index_d;
  logic             prime_q, prime_d;
  logic [5:0]       snapSec_q, snapSec_d;
  logic [5:0]       snapMin_q, snapMin_d;
  logic [4:0]       snapHour_q, snapHour_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       cat_q, cat_d;

  logic             tick;
  logic             capture;
  logic [7:0]       secBcd, minBcd, hourBcd;
  logic             secBad, minBad, hourBad;
  logic [7:0]       digitCode;

  // Binary to {tens, units} by repeated subtraction of ten. Six steps cover
  // every 6-bit value; results above 59 are replaced by "E" downstream, so
  // only the in-range part of the result is ever shown.
  function automatic logic [7:0] toBcd(input logic [5:0] value);
    logic [3:0] tens;
    logic [5:0] rest;
    tens = 4'd0;
    rest = value;
    for (int k = 0; k < 6; k++) begin
      if (rest >= 6'd10) begin
        rest = rest - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rest[3:0]};
  endfunction

  function automatic logic [7:0] segCode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  assign tick = (refreshCnt_q == CNT_LAST);

  // Capture on the very first edge after reset so the display never waits a
  // whole frame for real data, then once per frame on the 7->0 wrap.
  assign capture = prime_q || (tick && (index_q == 3'd7));

  assign secBcd  = toBcd(snapSec_q);
  assign minBcd  = toBcd(snapMin_q);
  assign hourBcd = toBcd({1'b0, snapHour_q});

  assign secBad  = (snapSec_q  > 6'd59);
  assign minBad  = (snapMin_q  > 6'd59);
  assign hourBad = (snapHour_q > 5'd23);

  // Digit selection for the current scan position: 7..6 hours, 4..3 minutes,
  // 1..0 seconds, 5 and 2 are separators.
  always_comb begin
    digitCode = SEG_BLANK;
    case (index_q)
      3'd7: digitCode = hourBad ? SEG_E : segCode(hourBcd[7:4]);
      3'd6: digitCode = hourBad ? SEG_E : segCode(hourBcd[3:0]);
      3'd4: digitCode = minBad  ? SEG_E : segCode(minBcd[7:4]);
      3'd3: digitCode = minBad  ? SEG_E : segCode(minBcd[3:0]);
      3'd1: digitCode = secBad  ? SEG_E : segCode(secBcd[7:4]);
      3'd0: digitCode = secBad  ? SEG_E : segCode(secBcd[3:0]);
      default: begin
`ifdef SEPARATOR_BLINK_EN
        digitCode = snapSec_q[0] ? SEG_BLANK : SEG_DASH;
`else
        digitCode = SEG_DASH;
`endif
      end
    endcase
  end

  always_comb begin
    refreshCnt_d = tick ? '0 : refreshCnt_q + CNT_ONE;
    index_d      = tick ? index_q + 3'd1 : index_q;
    prime_d      = 1'b0;
    snapSec_d    = snapSec_q;
    snapMin_d    = snapMin_q;
    snapHour_d   = snapHour_q;
    if (capture) begin
      snapSec_d  = disp.seconds_i;
      snapMin_d  = disp.minutes_i;
      snapHour_d = disp.hours_i;
    end
    an_d  = ~(8'd1 << index_q);
    cat_d = {1'b1, digitCode[6:0]};
  end

  always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
    if (reset_i) begin
      refreshCnt_q <= '0;
      index_q      <= 3'd0;
      prime_q      <= 1'b1;
      snapSec_q    <= 6'd0;
      snapMin_q    <= 6'd0;
      snapHour_q   <= 5'd0;
      an_q         <= 8'hFF;
      cat_q        <= 8'hFF;
    end else begin
      refreshCnt_q <= refreshCnt_d;
      index_q      <= index_d;
      prime_q      <= prime_d;
      snapSec_q    <= snapSec_d;
      snapMin_q    <= snapMin_d;
      snapHour_q   <= snapHour_d;
      an_q         <= an_d;
      cat_q        <= cat_d;
    end
  end

  assign disp.an_o      = an_q;
  assign disp.dec_cat_o = cat_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// -----------------------------------------------------------------------------
// tb_clock_display_driver
//
// Drives clock_display_driver with REFRESH_DIV=4 through directed steps and a
// randomized section. Expected pins come from a reference model that works
// from the post-reset edge count: the digit shown after edge n is
// ((n-1)/REFRESH_DIV) mod 8, and the time in use is the value that was on the
// inputs at edge 1 or at the most recent edge that is a multiple of a frame.
// -----------------------------------------------------------------------------
module tb_clock_display_driver;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  // 0-9 digits, 10 dash, 11 E, 12 blank
  localparam logic [7:0] SEG_TABLE [13] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
    8'hBF, 8'h86, 8'hFF
  };

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_display_driver_if bus ();

  clock_display_driver #(
    .REFRESH_DIV (D),
    .CNT_W       (3)
  ) dut (
    .clk_100MHz_i (clk),
    .reset_i      (rst),
    .disp         (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int edgeN       = 0;
  int snapH       = 0;
  int snapM       = 0;
  int snapS       = 0;

  function automatic logic [7:0] expSeg(input int idx);
    int v;
    int limit;
    if (idx == 5 || idx == 2) begin
`ifdef SEPARATOR_BLINK_EN
      return (snapS % 2 == 1) ? SEG_TABLE[12] : SEG_TABLE[10];
`else
      return SEG_TABLE[10];
`endif
    end
    if (idx >= 6) begin
      v = snapH; limit = 23;
    end else if (idx >= 3) begin
      v = snapM; limit = 59;
    end else begin
      v = snapS; limit = 59;
    end
    if (v > limit) return SEG_TABLE[11];
    if (idx % 3 == 1) return SEG_TABLE[v / 10];
    return SEG_TABLE[v % 10];
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s edge=%0d observed=%h expected=%h",
               tag, edgeN, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int h, input int m, input int s);
    bus.hours_i   = 5'(h);
    bus.minutes_i = 6'(m);
    bus.seconds_i = 6'(s);
  endtask

  task automatic resetModel();
    edgeN = 0;
    snapH = 0;
    snapM = 0;
    snapS = 0;
  endtask

  // One clock edge with reset released: predict, then check 1 time unit later.
  task automatic stepCycle();
    int idx;
    logic [7:0] eAn;
    logic [7:0] eSeg;
    @(posedge clk);
    edgeN++;
    idx  = ((edgeN - 1) / D) % 8;
    eAn  = ~(8'd1 << idx);
    eSeg = expSeg(idx);
    if (edgeN == 1 || edgeN % FRAME == 0) begin
      snapH = int'(bus.hours_i);
      snapM = int'(bus.minutes_i);
      snapS = int'(bus.seconds_i);
    end
    #1;
    checkOutput("an_o", bus.an_o, eAn);
    checkOutput("dec_cat_o", bus.dec_cat_o, eSeg);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    $display("[TB] start, REFRESH_DIV=%0d", D);

    // Power-on reset: dark display, also across clock edges.
    applyStimulus(12, 34, 56);
    #12;
    checkOutput("reset_an", bus.an_o, 8'hFF);
    checkOutput("reset_cat", bus.dec_cat_o, 8'hFF);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_an", bus.an_o, 8'hFF);
    checkOutput("reset_hold_cat", bus.dec_cat_o, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    // 12-34-56 held for two frames.
    runCycles(2 * FRAME);

    // Seconds change while index 3 is lit; visible only next frame.
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((edgeN - 1) / D) % 8 == 3 && (edgeN - 1) % D == 1)
        applyStimulus(12, 34, 57);
      stepCycle();
    end

    // Out-of-range hours and minutes, valid seconds 09.
    applyStimulus(24, 60, 9);
    runCycles(2 * FRAME);

    // Separator behaviour with odd and even seconds.
    applyStimulus(23, 59, 7);
    runCycles(2 * FRAME);
    applyStimulus(0, 0, 8);
    runCycles(2 * FRAME);

    // Reset in the middle of the scan while index 5 is lit.
    for (int i = 0; i < FRAME; i++) begin
      if (((edgeN - 1) / D) % 8 == 5) break;
      stepCycle();
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_an", bus.an_o, 8'hFF);
    checkOutput("midreset_cat", bus.dec_cat_o, 8'hFF);
    applyStimulus(5, 7, 42);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    runCycles(2 * FRAME);

    // Randomized section: fields include out-of-range values and change at
    // random points, including on frame-wrap edges.
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 63)));
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
